game_screen_anim: RTL and testbench

- Parametrised animated game screen for the 96x64 RGB565 OLED.
- Replaces the static single-colour screen with a registered pixel renderer, a bouncing square sprite and a corner-hit flash effect.
- The OLED driver supplies pixel coordinates (x, y) and a once-per-frame frame_tick. The block returns oled_data one cycle later.
- Sits between the OLED driver and the top-level screen select mux.

---
 rtl/game_screen_pkg.sv | 22 ++
 rtl/axis_mover.sv | 81 ++++++++
 rtl/game_screen_anim.sv | 175 +++++++++++++++++
 tb/tb_game_screen_anim.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_screen_pkg.sv
// Shared colour constants and state encoding for the animated game screen.
package game_screen_pkg;

  // RGB565 palette
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] PURPLE  = 16'hF81F;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] BROWN   = 16'h8204;
  localparam logic [15:0] SKYBLUE = 16'h5FFF;

  // Screen state, exported on the state port as a raw 2-bit code
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    FLASH = 2'd2
  } state_t;

endpackage

// File: rtl/axis_mover.sv
// One axis of the bouncing sprite: position register, direction flag and
// edge-hit detection. dir=1 means moving towards LIM, dir=0 towards 0.
// hit is combinational and only asserted on an accepted tick.
module axis_mover #(
  parameter int LIM  = 88,
  parameter int STEP = 1,
  parameter int W    = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_en,
  input  logic         restore,
  output logic [W-1:0] pos,
  output logic         dir,
  output logic         hit
);

  // One extra bit keeps pos+STEP from wrapping before the limit compare
  localparam logic [W:0]   LIM_W   = (W+1)'(LIM);
  localparam logic [W:0]   STEP_W  = (W+1)'(STEP);
  localparam logic [W-1:0] RST_POS = W'(LIM / 2);

  logic [W-1:0] pos_r;
  logic [W-1:0] pos_next_s;
  logic         dir_r;
  logic         dir_next_s;
  logic         hit_s;
  logic [W:0]   pos_up_s;
  logic [W:0]   pos_down_s;

  assign pos_up_s   = {1'b0, pos_r} + STEP_W;
  assign pos_down_s = {1'b0, pos_r} - STEP_W;

  // Next position/direction: restore beats a tick, edges clamp and reverse
  always_comb begin
    pos_next_s = pos_r;
    dir_next_s = dir_r;
    hit_s      = 1'b0;
    if (restore) begin
      pos_next_s = RST_POS;
      dir_next_s = 1'b1;
    end else if (tick_en) begin
      if (dir_r) begin
        if (pos_up_s > LIM_W) begin
          pos_next_s = LIM_W[W-1:0];
          dir_next_s = 1'b0;
          hit_s      = 1'b1;
        end else begin
          pos_next_s = pos_up_s[W-1:0];
        end
      end else begin
        if ({1'b0, pos_r} < STEP_W) begin
          pos_next_s = {W{1'b0}};
          dir_next_s = 1'b1;
          hit_s      = 1'b1;
        end else begin
          pos_next_s = pos_down_s[W-1:0];
        end
      end
    end else begin
      pos_next_s = pos_r;
      dir_next_s = dir_r;
    end
  end

  // Position and direction registers, centred and heading +1 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_r <= RST_POS;
      dir_r <= 1'b1;
    end else begin
      pos_r <= pos_next_s;
      dir_r <= dir_next_s;
    end
  end

  assign pos = pos_r;
  assign dir = dir_r;
  assign hit = hit_s;

endmodule

// File: rtl/game_screen_anim.sv
// Animated 96x64 RGB565 game screen: bouncing square sprite on a purple
// background with a white strobe when the sprite lands in a corner.
// oled_data is registered one cycle behind the requested x/y.
module game_screen_anim #(
  parameter int          WIDTH        = 96,
  parameter int          HEIGHT       = 64,
  parameter int          SPR_SIZE     = 8,
  parameter int          STEP         = 1,
  parameter int          FLASH_FRAMES = 6,
  parameter logic [15:0] BG_COLOUR    = 16'hF81F,
  parameter logic [15:0] SPR_COLOUR   = 16'hFFE0,
  parameter logic [15:0] FLASH_COLOUR = 16'hFFFF,
  localparam int         XW           = $clog2(WIDTH),
  localparam int         YW           = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          frame_tick,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [15:0]   oled_data,
  output logic          bounce,
  output logic [1:0]    state
);

  import game_screen_pkg::*;

  localparam int         FW      = $clog2(FLASH_FRAMES + 1);
  localparam logic [XW:0] WIDTH_W  = (XW+1)'(WIDTH);
  localparam logic [YW:0] HEIGHT_W = (YW+1)'(HEIGHT);
  localparam logic [XW:0] SPR_X_W  = (XW+1)'(SPR_SIZE);
  localparam logic [YW:0] SPR_Y_W  = (YW+1)'(SPR_SIZE);

  state_t         state_r;
  state_t         state_next_s;
  logic [FW-1:0]  flash_cnt_r;
  logic [FW-1:0]  flash_next_s;
  logic           bounce_r;
  logic           bounce_next_s;
  logic [15:0]    oled_data_r;
  logic [15:0]    pix_s;
  logic [15:0]    play_pix_s;
  logic           tick_en_s;
  logic           hit_x_s;
  logic           hit_y_s;
  logic [XW-1:0]  spr_x_s;
  logic [YW-1:0]  spr_y_s;
  logic           dir_x_unused_s;
  logic           dir_y_unused_s;
  logic [XW:0]    x_ext_s;
  logic [YW:0]    y_ext_s;
  logic           in_spr_s;
  logic           off_screen_s;

  // Movement only advances on a PLAY tick that is not being overridden by stop
  assign tick_en_s = frame_tick && !stop && (state_r == PLAY);

  axis_mover #(
    .LIM  (WIDTH - SPR_SIZE),
    .STEP (STEP),
    .W    (XW)
  ) u_mover_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_en (tick_en_s),
    .restore (stop),
    .pos     (spr_x_s),
    .dir     (dir_x_unused_s),
    .hit     (hit_x_s)
  );

  axis_mover #(
    .LIM  (HEIGHT - SPR_SIZE),
    .STEP (STEP),
    .W    (YW)
  ) u_mover_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_en (tick_en_s),
    .restore (stop),
    .pos     (spr_y_s),
    .dir     (dir_y_unused_s),
    .hit     (hit_y_s)
  );

  // Next state, flash counter and bounce pulse; stop overrides everything
  always_comb begin
    state_next_s  = state_r;
    flash_next_s  = flash_cnt_r;
    bounce_next_s = 1'b0;
    if (stop) begin
      state_next_s = IDLE;
      flash_next_s = {FW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_next_s = PLAY;
          end else begin
            state_next_s = IDLE;
          end
        end
        PLAY: begin
          bounce_next_s = hit_x_s | hit_y_s;
          if (hit_x_s && hit_y_s) begin
            state_next_s = FLASH;
            flash_next_s = FW'(FLASH_FRAMES);
          end else begin
            state_next_s = PLAY;
          end
        end
        FLASH: begin
          if (frame_tick) begin
            if (flash_cnt_r == FW'(1)) begin
              state_next_s = PLAY;
              flash_next_s = {FW{1'b0}};
            end else begin
              flash_next_s = flash_cnt_r - FW'(1);
            end
          end else begin
            flash_next_s = flash_cnt_r;
          end
        end
        default: begin
          state_next_s = IDLE;
          flash_next_s = {FW{1'b0}};
        end
      endcase
    end
  end

  assign x_ext_s      = {1'b0, x};
  assign y_ext_s      = {1'b0, y};
  assign off_screen_s = (x_ext_s >= WIDTH_W) || (y_ext_s >= HEIGHT_W);
  assign in_spr_s     = (x_ext_s >= {1'b0, spr_x_s}) && (x_ext_s < ({1'b0, spr_x_s} + SPR_X_W)) &&
                        (y_ext_s >= {1'b0, spr_y_s}) && (y_ext_s < ({1'b0, spr_y_s} + SPR_Y_W));

  // Pixel colour for the requested coordinate from the current state/position
  always_comb begin
    play_pix_s = in_spr_s ? SPR_COLOUR : BG_COLOUR;
    pix_s      = BLACK;
    if (off_screen_s) begin
      pix_s = BLACK;
    end else begin
      case (state_r)
        IDLE:    pix_s = BG_COLOUR;
        PLAY:    pix_s = play_pix_s;
        FLASH:   pix_s = flash_cnt_r[0] ? play_pix_s : FLASH_COLOUR;
        default: pix_s = BLACK;
      endcase
    end
  end

  // State, counter, bounce and pixel registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      flash_cnt_r <= {FW{1'b0}};
      bounce_r    <= 1'b0;
      oled_data_r <= 16'h0000;
    end else begin
      state_r     <= state_next_s;
      flash_cnt_r <= flash_next_s;
      bounce_r    <= bounce_next_s;
      oled_data_r <= pix_s;
    end
  end

  assign oled_data = oled_data_r;
  assign bounce    = bounce_r;
  assign state     = state_r;

endmodule

// File: tb/tb_game_screen_anim.sv
// Bench for game_screen_anim: a default 96x64 instance (a) and a 64x64
// instance (b) share control inputs; each has its own pixel coordinates.
module tb_game_screen_anim;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        frame_tick;
  logic [6:0]  xa;
  logic [5:0]  ya;
  logic [5:0]  xb;
  logic [5:0]  yb;
  logic [15:0] oa;
  logic [15:0] ob;
  logic        ba;
  logic        bb;
  logic [1:0]  sa;
  logic [1:0]  sb;

  game_screen_anim dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .frame_tick (frame_tick),
    .x          (xa),
    .y          (ya),
    .oled_data  (oa),
    .bounce     (ba),
    .state      (sa)
  );

  game_screen_anim #(.WIDTH(64), .HEIGHT(64)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .frame_tick (frame_tick),
    .x          (xb),
    .y          (yb),
    .oled_data  (ob),
    .bounce     (bb),
    .state      (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ph;
    logic [6:0]  xa;
    logic [5:0]  ya;
    logic [15:0] ea;
    logic [5:0]  xb;
    logic [5:0]  yb;
    logic [15:0] eb;
  } vec_t;

  typedef struct {
    string       nm;
    logic [15:0] ea;
    logic [15:0] eb;
  } sb_t;

  vec_t vq[$];
  sb_t  sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [15:0] BGC = 16'hF81F;
  localparam logic [15:0] SPC = 16'hFFE0;
  localparam logic [15:0] FLC = 16'hFFFF;
  localparam logic [15:0] BLK = 16'h0000;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input int ph, input int xa_i, input int ya_i, input logic [15:0] ea,
                     input int xb_i, input int yb_i, input logic [15:0] eb);
    vec_t v;
    v.ph = ph; v.xa = 7'(xa_i); v.ya = 6'(ya_i); v.ea = ea;
    v.xb = 6'(xb_i); v.yb = 6'(yb_i); v.eb = eb;
    vq.push_back(v);
  endtask

  // Drive one coordinate pair, queue the expectation, compare one cycle later
  task automatic pix(input int xa_i, input int ya_i, input logic [15:0] ea,
                     input int xb_i, input int yb_i, input logic [15:0] eb);
    sb_t e;
    xa = 7'(xa_i); ya = 6'(ya_i); xb = 6'(xb_i); yb = 6'(yb_i);
    sbq.push_back('{$sformatf("pix a(%0d,%0d) b(%0d,%0d)", xa_i, ya_i, xb_i, yb_i), ea, eb});
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk({e.nm, " a"}, oa, e.ea);
    chk({e.nm, " b"}, ob, e.eb);
  endtask

  task automatic run_phase(input int ph);
    foreach (vq[i]) begin
      if (vq[i].ph == ph) pix(vq[i].xa, vq[i].ya, vq[i].ea, vq[i].xb, vq[i].yb, vq[i].eb);
    end
  endtask

  task automatic do_tick(input string nm, input logic eba, input logic ebb);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    chk({nm, " bounce a"}, {15'd0, ba}, {15'd0, eba});
    chk({nm, " bounce b"}, {15'd0, bb}, {15'd0, ebb});
  endtask

  task automatic pulse(input logic s, input logic t);
    start = s; stop = t;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic states(input string nm, input logic [1:0] ea, input logic [1:0] eb);
    chk({nm, " state a"}, {14'd0, sa}, {14'd0, ea});
    chk({nm, " state b"}, {14'd0, sb}, {14'd0, eb});
  endtask

  // Reach the first corner from a fresh start: 28 quiet ticks then the hit
  task automatic run_to_corner(input string nm);
    for (int t = 1; t <= 28; t++) do_tick($sformatf("%s t%0d", nm, t), 1'b0, 1'b0);
    do_tick($sformatf("%s t29", nm), 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // phase 0: IDLE screen (a reset sprite 44,28; b reset sprite 28,28)
    add(0,   0,  0, BGC,  0,  0, BGC);
    add(0, 100, 10, BLK, 63, 63, BGC);
    add(0,  96,  0, BLK, 36, 10, BGC);
    add(0,  95, 63, BGC,  0, 63, BGC);
    add(0,  44, 28, BGC, 28, 28, BGC);
    // phase 1: PLAY at reset position
    add(1,  44, 28, SPC, 28, 28, SPC);
    add(1,  43, 28, BGC, 27, 28, BGC);
    add(1,  51, 35, SPC, 35, 35, SPC);
    add(1,  52, 35, BGC, 36, 35, BGC);
    add(1,  44, 27, BGC, 28, 27, BGC);
    add(1,  51, 36, BGC, 35, 36, BGC);
    add(1, 127,  0, BLK, 44, 28, BGC);
    // phase 2: after 28 ticks, a at 72,56, b at 56,56
    add(2,  72, 56, SPC, 56, 56, SPC);
    add(2,  79, 63, SPC, 63, 63, SPC);
    add(2,  71, 56, BGC, 55, 56, BGC);
    add(2,  72, 55, BGC, 56, 55, BGC);
    add(2,  80, 63, BGC,  0,  0, BGC);
    // phase 3: after 35 ticks, a at 79,50, b back in PLAY still at 56,56
    add(3,  79, 50, SPC, 56, 56, SPC);
    add(3,  78, 50, BGC, 63, 63, SPC);
    add(3,  79, 49, BGC, 55, 55, BGC);
    add(3,  86, 57, SPC, 56, 55, BGC);
    add(3,  87, 57, BGC,  0,  0, BGC);
    // phase 4: after 36 ticks, a at 80,49, b at 55,55
    add(4,  80, 49, SPC, 55, 55, SPC);
    add(4,  79, 49, BGC, 62, 62, SPC);
    add(4,  87, 56, SPC, 63, 63, BGC);
    // phase 5: restarted at reset position
    add(5,  44, 28, SPC, 28, 28, SPC);
    add(5,  43, 27, BGC, 27, 27, BGC);
    // phase 6: one tick later, both moving +1,+1 again
    add(6,  45, 29, SPC, 29, 29, SPC);
    add(6,  44, 28, BGC, 28, 28, BGC);
    add(6,  52, 36, SPC, 36, 36, SPC);

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; frame_tick = 1'b0;
    xa = 7'd0; ya = 6'd0; xb = 6'd0; yb = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset oled a", oa, BLK);
    chk("reset oled b", ob, BLK);
    chk("reset bounce a", {15'd0, ba}, 16'd0);
    states("reset", 2'd0, 2'd0);
    // inputs are ignored while held in reset
    xa = 7'd100; ya = 6'd10; start = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1;
    chk("reset hold oled a", oa, BLK);
    states("reset hold", 2'd0, 2'd0);
    start = 1'b0; frame_tick = 1'b0;
    rst_n = 1'b1;

    run_phase(0);
    states("idle", 2'd0, 2'd0);

    pulse(1'b1, 1'b0);
    states("start", 2'd1, 2'd1);
    run_phase(1);

    for (int t = 1; t <= 28; t++) do_tick($sformatf("tick%0d", t), 1'b0, 1'b0);
    states("after 28", 2'd1, 2'd1);
    run_phase(2);

    // tick 29: a bounces off the bottom, b hits the corner
    do_tick("tick29", 1'b1, 1'b1);
    states("after 29", 2'd1, 2'd2);
    @(posedge clk); #1;
    chk("bounce width a", {15'd0, ba}, 16'd0);
    chk("bounce width b", {15'd0, bb}, 16'd0);

    for (int t = 30; t <= 35; t++) begin
      logic [15:0] e00;
      logic [15:0] e56;
      int cnt;
      do_tick($sformatf("tick%0d", t), 1'b0, 1'b0);
      cnt = 35 - t;
      states($sformatf("flash t%0d", t), 2'd1, (t < 35) ? 2'd2 : 2'd1);
      e00 = ((cnt % 2) == 0 && t < 35) ? FLC : BGC;
      e56 = ((cnt % 2) == 0 && t < 35) ? FLC : SPC;
      pix(0, 0, BGC, 0, 0, e00);
      pix(0, 0, BGC, 56, 56, e56);
    end
    run_phase(3);
    do_tick("tick36", 1'b0, 1'b0);
    run_phase(4);

    // start and stop together: stop wins, everything back to reset values
    pulse(1'b1, 1'b1);
    states("start+stop", 2'd0, 2'd0);
    run_phase(0);
    pulse(1'b1, 1'b0);
    states("restart", 2'd1, 2'd1);
    run_phase(5);
    do_tick("restart tick", 1'b0, 1'b0);
    run_phase(6);

    // stop during FLASH
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    run_to_corner("run2");
    states("run2 corner", 2'd1, 2'd2);
    pulse(1'b0, 1'b1);
    states("stop in flash", 2'd0, 2'd0);
    pix(44, 28, BGC, 28, 28, BGC);

    // asynchronous reset mid-FLASH
    pulse(1'b1, 1'b0);
    run_to_corner("run3");
    xa = 7'd0; ya = 6'd0; xb = 6'd0; yb = 6'd0;
    do_tick("run3 t30", 1'b0, 1'b0);
    states("run3 flash", 2'd1, 2'd2);
    chk("pre-reset oled b", ob, FLC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset oled a", oa, BLK);
    chk("async reset oled b", ob, BLK);
    states("async reset", 2'd0, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pix(44, 28, BGC, 28, 28, BGC);
    states("after reset", 2'd0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
